// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, frame bit levels and the parity helper.
// Used by ps2_rx_fifo and ps2_sync_fifo.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    localparam logic PS2_START_LEVEL = 1'b0;
    localparam logic PS2_STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead receive FIFO for PS/2 bytes; DEPTH must be a power of two so pointers wrap naturally.
// Simultaneous push and pop on a full FIFO both succeed; a pop on an empty FIFO is ignored.
module ps2_sync_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [PS2_DATA_BITS-1:0]   wr_data,
    input  logic                       rd_en,
    output logic [PS2_DATA_BITS-1:0]   rd_data,
    output logic                       wr_accept,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_wr, do_rd;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != DEPTH_C) || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;
    assign wr_accept = do_wr;
    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive controller: line synchroniser, glitch filter, frame FSM with timeout, sticky flags and RX FIFO.
// Define PS2_PARITY_CHECK_EN to drop bytes with bad odd parity; otherwise the parity bit is ignored.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       rd_en,
    input  logic                       int_clear,
    input  logic                       err_clear,
    output logic [PS2_DATA_BITS-1:0]   data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       valid,
    output logic                       interrupt,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int LINE_CLK  = 0;
    localparam int LINE_DATA = 1;
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam int BCW = $clog2(PS2_DATA_BITS);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(PS2_DATA_BITS - 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_BYPASS = 1'b0;
`else
    localparam logic PARITY_BYPASS = 1'b1;
`endif

    logic [1:0]                   raw_lines;
    logic [1:0][SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [1:0][FCW-1:0]          fcnt_q, fcnt_d;
    logic [1:0]                   filt_q, filt_d;
    logic                         clk_prev_q, clk_prev_d;
    logic                         sample_evt;
    logic                         line_data;

    ps2_state_e                   state_q, state_d;
    logic [BCW-1:0]               bitcnt_q, bitcnt_d;
    logic [PS2_DATA_BITS-1:0]     shift_q, shift_d;
    logic                         parity_q, parity_d;
    logic [TCW-1:0]               to_cnt_q, to_cnt_d;
    logic                         timeout_hit;
    logic                         parity_ok;
    logic                         ferr_set;

    logic                         push_q, push_d;
    logic [PS2_DATA_BITS-1:0]     push_byte_q, push_byte_d;
    logic                         fifo_wr_accept;

    logic                         valid_q, valid_d;
    logic                         interrupt_q, interrupt_d;
    logic                         overflow_q, overflow_d;
    logic                         frame_err_q, frame_err_d;

    assign raw_lines = {ps2_data, ps2_clk};

    // A filtered line only follows its synchronised input after FILTER_LEN identical samples in a row.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_lines[i]};
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync_q[i][SYNC_STAGES-1];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign clk_prev_d  = filt_q[LINE_CLK];
    assign sample_evt  = clk_prev_q && !filt_q[LINE_CLK];
    assign line_data   = filt_q[LINE_DATA];
    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_LAST);
    assign parity_ok   = PARITY_BYPASS || odd_parity_ok(shift_q, parity_q);

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        ferr_set    = 1'b0;
        to_cnt_d    = '0;
        if (state_q != IDLE && !sample_evt) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (sample_evt) begin
            case (state_q)
                IDLE: begin
                    if (line_data == PS2_START_LEVEL) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {line_data, shift_q[PS2_DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = line_data;
                    state_d  = STOP;
                end
                STOP: begin
                    if (line_data == PS2_STOP_LEVEL && parity_ok) begin
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            ferr_set = 1'b1;
            state_d  = IDLE;
            shift_d  = '0;
            to_cnt_d = '0;
        end
    end

    ps2_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push_q),
        .wr_data   (push_byte_q),
        .rd_en     (rd_en),
        .rd_data   (data_out),
        .wr_accept (fifo_wr_accept),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    // Sticky flags: a set arriving in the same cycle as its clear takes priority.
    always_comb begin
        valid_d     = fifo_wr_accept;
        interrupt_d = fifo_wr_accept || (interrupt_q && !int_clear);
        overflow_d  = (push_q && !fifo_wr_accept) || (overflow_q && !err_clear);
        frame_err_d = ferr_set || (frame_err_q && !err_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            fcnt_q      <= '0;
            filt_q      <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            valid_q     <= 1'b0;
            interrupt_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            fcnt_q      <= fcnt_d;
            filt_q      <= filt_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            valid_q     <= valid_d;
            interrupt_q <= interrupt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign valid     = valid_q;
    assign interrupt = interrupt_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frames, hand-written corner sequences and
// random frames compared against a queue-based model of the receive rules.
module tb_ps2_rx_fifo;

    localparam int DEPTH          = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int LATENCY        = SYNC_STAGES + FILTER_LEN + 2;
    localparam int HALF           = 20;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       int_clear;
    logic       err_clear;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       valid;
    logic       interrupt;
    logic       overflow;
    logic       frame_err;

    ps2_rx_fifo #(
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .int_clear (int_clear),
        .err_clear (err_clear),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .valid     (valid),
        .interrupt (interrupt),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt   = 0;
    int valid_cnt   = 0;
    int valid_cycle = -1;
    int stop_fall_cycle = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt   <= valid_cnt + 1;
            valid_cycle <= cycle_cnt;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         par_flip;
        bit         stop_bit;
        int         exp_count;
        logic [7:0] exp_head;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_int_clear();
        int_clear = 1'b1;
        cyc(1);
        int_clear = 1'b0;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH && empty == 1'b0; k++) pop();
    endtask

    // One PS/2 bit: data set mid-high, then a falling clock edge held low for HALF cycles.
    task automatic ps2_bit(input logic v, input bit glitch, input bit pop_at_push);
        cyc(HALF / 2);
        ps2_data = v;
        if (glitch) begin
            cyc(3);
            ps2_clk = 1'b0;
            cyc(1);
            ps2_clk = 1'b1;
            cyc(HALF / 2 - 4);
        end else begin
            cyc(HALF / 2);
        end
        ps2_clk = 1'b0;
        stop_fall_cycle = cycle_cnt;
        if (pop_at_push) begin
            cyc(LATENCY - 1);
            rd_en     = 1'b1;
            int_clear = 1'b1;
            cyc(1);
            rd_en     = 1'b0;
            int_clear = 1'b0;
            cyc(HALF - LATENCY);
        end else if (glitch) begin
            cyc(10);
            ps2_clk = 1'b1;
            cyc(1);
            ps2_clk = 1'b0;
            cyc(HALF - 11);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit,
                              input bit glitch, input bit pop_at_push);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_bit(bits[i], glitch, pop_at_push && (i == 10));
        end
        cyc(HALF / 2);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},  data_out,  0);
        check({tag, "_empty"},     empty,     1);
        check({tag, "_full"},      full,      0);
        check({tag, "_count"},     count,     0);
        check({tag, "_valid"},     valid,     0);
        check({tag, "_interrupt"}, interrupt, 0);
        check({tag, "_overflow"},  overflow,  0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         v0;
        logic [7:0] q[$];
        bit         m_ferr;
        bit         m_ovf;
        int         m_acc;
        logic [7:0] b;
        bit         pf;
        bit         sb;
        bit         good;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b1, PAR_CHECK ? 0 : 1, PAR_CHECK ? 8'h00 : 8'h55, PAR_CHECK};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 0, 8'h00, 1'b1};
        vecs[5] = '{8'h3A, 1'b0, 1'b1, 1, 8'h3A, 1'b0};

        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rd_en     = 1'b0;
        int_clear = 1'b0;
        err_clear = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        cyc(5);

        // First byte: latency from the stop-bit clock fall to the valid pulse.
        v0 = valid_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lat_valid_pulses", valid_cnt - v0, 1);
        check("lat_cycles", valid_cycle - stop_fall_cycle, LATENCY);
        check("first_data_out", data_out, 8'h1C);
        check("first_count", count, 1);
        check("first_interrupt", interrupt, 1);
        check("first_frame_err", frame_err, 0);
        pulse_int_clear();
        check("int_clear", interrupt, 0);
        pop();
        check("first_pop_empty", empty, 1);

        // Table of single frames, each starting from an empty FIFO with clear error flags.
        for (int r = 0; r < 6; r++) begin
            v0 = valid_cnt;
            send_frame(vecs[r].data, vecs[r].par_flip, vecs[r].stop_bit, 1'b0, 1'b0);
            check($sformatf("vec%0d_count", r), count, vecs[r].exp_count);
            check($sformatf("vec%0d_head", r), data_out, vecs[r].exp_head);
            check($sformatf("vec%0d_frame_err", r), frame_err, vecs[r].exp_ferr);
            check($sformatf("vec%0d_valid_pulses", r), valid_cnt - v0, vecs[r].exp_count);
            drain();
            pulse_err_clear();
        end

        // Overflow: DEPTH+1 frames without reads.
        v0 = valid_cnt;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_count", count, DEPTH);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_valid_pulses", valid_cnt - v0, DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("ovf_pop%0d", i), data_out, i);
            pop();
        end
        check("ovf_empty", empty, 1);
        check("ovf_empty_data", data_out, 0);
        pulse_err_clear();
        check("ovf_err_clear", overflow, 0);

        // Timeout: start bit plus four data bits, then the clock stays high.
        b = 8'hAA;
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0, 1'b0);
        cyc(20);
        check("to_before", frame_err, 0);
        cyc(TIMEOUT_CYCLES);
        check("to_frame_err", frame_err, 1);
        check("to_count", count, 0);
        ps2_data = 1'b1;
        pulse_err_clear();
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        check("to_next_data", data_out, 8'hAA);
        check("to_next_count", count, 1);
        check("to_next_frame_err", frame_err, 0);
        drain();

        // Single-cycle glitches on ps2_clk in both phases of every bit.
        send_frame(8'h3A, 1'b0, 1'b1, 1'b1, 1'b0);
        check("glitch_data", data_out, 8'h3A);
        check("glitch_count", count, 1);
        check("glitch_frame_err", frame_err, 0);
        drain();

        // Full FIFO with rd_en and int_clear both high in the push cycle.
        pulse_int_clear();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_int_clear();
        check("fullrd_pre_interrupt", interrupt, 0);
        send_frame(8'h14, 1'b0, 1'b1, 1'b0, 1'b1);
        check("fullrd_count", count, DEPTH);
        check("fullrd_full", full, 1);
        check("fullrd_overflow", overflow, 0);
        check("fullrd_interrupt", interrupt, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("fullrd_pop%0d", i), data_out, 8'h10 + 8'(i));
            pop();
        end
        check("fullrd_empty", empty, 1);

        // Random frames against a queue model of the acceptance rules.
        pulse_err_clear();
        pulse_int_clear();
        q      = {};
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            pf   = ($urandom_range(0, 5) == 0);
            sb   = ($urandom_range(0, 7) != 0);
            good = sb && !(pf && PAR_CHECK);
            m_acc = 0;
            if (!good) begin
                m_ferr = 1'b1;
            end else if (q.size() < DEPTH) begin
                q.push_back(b);
                m_acc = 1;
            end else begin
                m_ovf = 1'b1;
            end
            v0 = valid_cnt;
            send_frame(b, pf, sb, 1'b0, 1'b0);
            check($sformatf("rnd%0d_count", n), count, q.size());
            check($sformatf("rnd%0d_head", n), data_out, (q.size() != 0) ? q[0] : 8'h00);
            check($sformatf("rnd%0d_frame_err", n), frame_err, m_ferr);
            check($sformatf("rnd%0d_overflow", n), overflow, m_ovf);
            check($sformatf("rnd%0d_valid_pulses", n), valid_cnt - v0, m_acc);
            repeat ($urandom_range(0, 2)) begin
                pop();
                if (q.size() != 0) void'(q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_err_clear();
                m_ferr = 1'b0;
                m_ovf  = 1'b0;
            end
        end

        // Reset in the middle of a frame with data already queued.
        drain();
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_pre_count", count, 1);
        ps2_bit(1'b0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1);
        check_reset_outputs("midrst");
        ps2_data = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        send_frame(8'h6B, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_count", count, 1);
        check("post_rst_data", data_out, 8'h6B);
        check("post_rst_frame_err", frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
